riscv_crypto_sm3_cf: RTL and testbench

Multi-cycle SM3 compression function engine: takes one 512-bit message block and a 256-bit chaining value, runs the 64 SM3 rounds with on-the-fly message expansion, and returns the new chaining value. It consumes the P0/P1 permutations that the single-cycle `ssm3.p0`/`ssm3.p1` instructions expose. It sits beside the scalar crypto FUs as a block-level accelerator behind a valid/ready request/response interface.

---
 rtl/riscv_crypto_sm3_pkg.sv | 34 +++
 rtl/riscv_crypto_sm3_round.sv | 27 ++
 rtl/riscv_crypto_sm3_cf.sv | 95 +++++++++
 tb/tb_riscv_crypto_sm3_cf.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_crypto_sm3_pkg.sv
// rtl/riscv_crypto_sm3_pkg.sv - SM3 constants, FSM state type and round helper functions
package riscv_crypto_sm3_pkg;

  localparam logic [31:0]  T_LO   = 32'h79cc4519;
  localparam logic [31:0]  T_HI   = 32'h7a879d8a;
  localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol32(x, 5'd9) ^ rol32(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
  endfunction

  function automatic logic [31:0] ff(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z, input logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] gg(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z, input logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

endpackage

// File: rtl/riscv_crypto_sm3_round.sv
// rtl/riscv_crypto_sm3_round.sv - one combinational SM3 compression round
module riscv_crypto_sm3_round
  import riscv_crypto_sm3_pkg::*;
(
  input  logic [255:0] state,
  input  logic [31:0]  w,
  input  logic [31:0]  w4,
  input  logic [5:0]   j,
  output logic [255:0] state_next
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] tj, a12, ss1, ss2, tt1, tt2;
  logic        hi;

  assign {a, b, c, d, e, f, g, h} = state;
  assign hi  = (j >= 6'd16);
  assign tj  = hi ? T_HI : T_LO;
  assign a12 = rol32(a, 5'd12);
  assign ss1 = rol32(a12 + e + rol32(tj, j[4:0]), 5'd7);
  assign ss2 = ss1 ^ a12;
  assign tt1 = ff(a, b, c, hi) + d + ss2 + (w ^ w4);
  assign tt2 = gg(e, f, g, hi) + h + ss1 + w;

  assign state_next = {tt1, a, rol32(b, 5'd9), c, p0(tt2), e, rol32(f, 5'd19), g};

endmodule

// File: rtl/riscv_crypto_sm3_cf.sv
// rtl/riscv_crypto_sm3_cf.sv - multi-cycle SM3 compression engine, UNROLL rounds per clock
module riscv_crypto_sm3_cf
  import riscv_crypto_sm3_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_v,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_v
);

  localparam logic [5:0] LAST_J = 6'(64 - UNROLL);

  state_t                         state, state_nxt;
  logic [5:0]                     j;
  logic [255:0]                   v_reg, work, work_next;
  logic [15:0][31:0]              win;
  logic [UNROLL+15:0][31:0]       ext;
  logic                           accept, last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_v     = (state == DONE) ? (work ^ v_reg) : '0;
  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (j == LAST_J);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= IDLE;
      j     <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        j <= '0;
      else if (state == RUN && !last_step)
        j <= j + 6'(UNROLL);
    end
  end

  // Window holds Wj..Wj+15; extend it by UNROLL words so each round finds Wj+4 in place.
  always_comb begin
    ext = '0;
    ext[15:0] = win;
    for (int k = 0; k < UNROLL; k++)
      ext[16+k] = p1(ext[k] ^ ext[k+7] ^ rol32(ext[k+13], 5'd15))
                  ^ rol32(ext[k+3], 5'd7) ^ ext[k+10];
  end

  for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
    logic [255:0] s_in, s_out;
    if (k == 0) begin : g_first
      assign s_in = work;
    end else begin : g_chain
      assign s_in = g_rnd[k-1].s_out;
    end
    riscv_crypto_sm3_round u_round (
      .state      (s_in),
      .w          (ext[k]),
      .w4         (ext[k+4]),
      .j          (j + 6'(k)),
      .state_next (s_out)
    );
  end

  assign work_next = g_rnd[UNROLL-1].s_out;

  always_ff @(posedge g_clk) begin
    if (accept) begin
      v_reg <= in_v;
      work  <= in_v;
      for (int i = 0; i < 16; i++)
        win[i] <= in_block[511-32*i -: 32];
    end else if (state == RUN) begin
      work <= work_next;
      win  <= ext[UNROLL+15:UNROLL];
    end
  end

endmodule

// File: tb/tb_riscv_crypto_sm3_cf.sv
// tb/tb_riscv_crypto_sm3_cf.sv - randomized bench for the SM3 engine at UNROLL 1, 2 and 4
module tb_riscv_crypto_sm3_cf;

  localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] ABC_DIG  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [511:0] ABCD_BLK = {16{32'h61626364}};
  localparam logic [511:0] PAD_BLK  = {32'h80000000, {14{32'h0}}, 32'h00000200};
  localparam logic [255:0] ABCD_DIG = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  logic         g_clk, g_reset, in_valid, out_ready;
  logic [255:0] in_v;
  logic [511:0] in_block;
  logic [2:0]   rdy, ovld;
  logic [255:0] ov [3];
  int           n_vec, n_err;
  logic [255:0] r, hold;

  riscv_crypto_sm3_cf #(.UNROLL(1)) u_dut1 (.g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid),
    .in_ready(rdy[0]), .in_v(in_v), .in_block(in_block), .out_valid(ovld[0]), .out_ready(out_ready), .out_v(ov[0]));
  riscv_crypto_sm3_cf #(.UNROLL(2)) u_dut2 (.g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid),
    .in_ready(rdy[1]), .in_v(in_v), .in_block(in_block), .out_valid(ovld[1]), .out_ready(out_ready), .out_v(ov[1]));
  riscv_crypto_sm3_cf #(.UNROLL(4)) u_dut4 (.g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid),
    .in_ready(rdy[2]), .in_v(in_v), .in_block(in_block), .out_valid(ovld[2]), .out_ready(out_ready), .out_v(ov[2]));

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // Reference compression written straight from the algorithm: full 68-word schedule.
  function automatic logic [255:0] sm3_ref(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] w [68];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, fv, gv, x;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 68; i++) begin
      x = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
      w[i] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[i-13], 7) ^ w[i-6];
    end
    {a, b, c, d, e, f, g, h} = v;
    for (int jj = 0; jj < 64; jj++) begin
      t   = (jj < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(a, 12) + e + rl(t, jj), 7);
      ss2 = ss1 ^ rl(a, 12);
      fv  = (jj < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      gv  = (jj < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = fv + d + ss2 + (w[jj] ^ w[jj+4]);
      tt2 = gv + h + ss1 + w[jj];
      d = c; c = rl(b, 9); b = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
    end
    return {a, b, c, d, e, f, g, h} ^ v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // rmode: 0 out_ready high, 1 out_ready low (result held), 2 random out_ready.
  task automatic run_req(input logic [255:0] v, input logic [511:0] blk, input int rmode,
                         input bit noise, output logic [255:0] res);
    logic [255:0] exp;
    logic [255:0] capt [3];
    int           lat [3];
    logic [2:0]   got;
    int           t, edges;
    exp = sm3_ref(v, blk);
    @(negedge g_clk);
    out_ready = 1'b1;
    t = 0;
    while (rdy !== 3'b111 && t < 300) begin
      @(negedge g_clk);
      t++;
    end
    chk("ready_before_req", {253'd0, rdy}, 256'd7);
    out_ready = (rmode == 1) ? 1'b0 : 1'b1;
    in_v = v; in_block = blk; in_valid = 1'b1;
    @(posedge g_clk);
    #1 in_valid = 1'b0;
    got = '0; edges = 0;
    while (got != 3'b111 && edges < 200) begin
      @(negedge g_clk);
      if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
      if (noise && rdy == 3'b000) begin
        in_valid = 1'($urandom_range(0, 1));
        in_v = rnd256(); in_block = rnd512();
      end else begin
        in_valid = 1'b0;
      end
      @(posedge g_clk);
      #1 edges++;
      for (int i = 0; i < 3; i++)
        if (!got[i] && ovld[i]) begin
          got[i] = 1'b1; capt[i] = ov[i]; lat[i] = edges + 1;
        end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done_u%0d", 1 << i), {255'd0, got[i]}, 256'd1);
      chk($sformatf("out_v_u%0d", 1 << i), capt[i], exp);
      chk($sformatf("latency_u%0d", 1 << i), 256'(lat[i]), 256'(64 / (1 << i) + 1));
    end
    res = capt[0];
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    g_reset = 1'b1; in_valid = 1'b0; in_v = '0; in_block = '0; out_ready = 1'b1;
    repeat (3) @(negedge g_clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready_u%0d", 1 << i), {255'd0, rdy[i]}, 256'd1);
      chk($sformatf("rst_out_valid_u%0d", 1 << i), {255'd0, ovld[i]}, 256'd0);
      chk($sformatf("rst_out_v_u%0d", 1 << i), ov[i], 256'd0);
    end
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("ready_after_release", {253'd0, rdy}, 256'd7);

    run_req(riscv_crypto_sm3_pkg::SM3_IV, ABC_BLK, 0, 1'b0, r);
    chk("abc_digest", r, ABC_DIG);

    run_req(riscv_crypto_sm3_pkg::SM3_IV, ABCD_BLK, 0, 1'b0, r);
    run_req(r, PAD_BLK, 0, 1'b0, r);
    chk("abcd16_digest", r, ABCD_DIG);

    run_req(riscv_crypto_sm3_pkg::SM3_IV, ABC_BLK, 1, 1'b0, r);
    hold = ov[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge g_clk);
      chk("bp_out_valid", {255'd0, ovld[0]}, 256'd1);
      chk("bp_out_v_held", ov[0], ABC_DIG);
      chk("bp_in_ready_low", {255'd0, rdy[0]}, 256'd0);
    end
    out_ready = 1'b1;
    @(posedge g_clk);
    #1;
    chk("bp_idle_ready", {253'd0, rdy}, 256'd7);
    chk("bp_idle_valid", {253'd0, ovld}, 256'd0);
    chk("bp_idle_out_v_zero", ov[0], 256'd0);

    @(negedge g_clk);
    in_v = riscv_crypto_sm3_pkg::SM3_IV; in_block = ABC_BLK; in_valid = 1'b1;
    @(posedge g_clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge g_clk);
    #1 g_reset = 1'b1;
    #1;
    chk("rst_run_out_valid", {253'd0, ovld}, 256'd0);
    chk("rst_run_in_ready", {253'd0, rdy}, 256'd7);
    repeat (2) @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("rst_rel_in_ready", {253'd0, rdy}, 256'd7);
    chk("rst_rel_out_valid", {253'd0, ovld}, 256'd0);
    run_req(riscv_crypto_sm3_pkg::SM3_IV, ABC_BLK, 0, 1'b0, r);
    chk("abc_after_reset", r, ABC_DIG);

    for (int n = 0; n < 5; n++)
      run_req(rnd256(), rnd512(), 2, 1'b1, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
